mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. Connects as one slave region of simple_interconnect, on the same we/addr/wd/rd slave interface as ram_1port.
- The core writes bytes to a TX FIFO. A serializer drains the FIFO as 8N1 frames on a single tx pin.
- Provides console output for firmware and simulation.
- Read data is registered (1-cycle latency), matching ram_1port timing.

Parameters:
- CLK_DIV, 434, reset value of the bit-period divisor in clk cycles (50 MHz / 115200).
- FIFO_DEPTH, 16, TX FIFO entries. Power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- we  input  1  write strobe from interconnect
- addr  input  32  byte address; only addr[3:2] decoded, region select done by interconnect
- wd  input  32  write data
- rd  output  32  registered read data
- tx  output  1  serial output, idle high
- irq  output  1  present only with UART_TX_IRQ_EN

Behaviour:
- Register map (addr[3:2]):
  - 0 = TXDATA: write pushes wd[7:0]; reads 0.
  - 1 = STATUS: bit0 full, bit1 empty, bit2 busy (serializer not IDLE), bit3 overflow (sticky), bits[12:8] FIFO count; other bits 0.
  - 2 = DIVISOR: R/W, bits[15:0]; upper bits read 0.
  - 3 = CTRL: bit0 irq_en; reads 0 when macro absent.
- Reset values: rd=0, tx=1, FIFO empty, count=0, overflow=0, DIVISOR=CLK_DIV[15:0], irq_en=0, irq=0, FSM=IDLE.
- Reset asserted mid-frame aborts the frame immediately: tx=1 and the FIFO is flushed.
- Read timing:
  - rd updates every clk from the addr sampled that cycle, whether or not we is asserted.
  - Data is valid the cycle after addr is presented.
  - STATUS reflects state before any same-cycle write takes effect.
- Overflow handling:
  - A TXDATA write while full drops the byte, sets overflow, and leaves count unchanged.
  - A STATUS write with wd[3]=1 clears overflow. Other STATUS bits are read-only.
- Push and pop in the same cycle when full: the push is accepted and count is unchanged.
- Push into an empty FIFO: the byte is visible to the serializer the next cycle.
- Divisor handling:
  - DIVISOR=0 is treated as 1.
  - The divisor is latched into the bit counter at frame start. A write mid-frame affects the next frame only.
- Serializer FSM, each bit held for exactly div clk cycles:
  - IDLE: if FIFO not empty, pop the head into the shift register, latch div, go to START.
  - START: tx=0 for div cycles, then DATA.
  - DATA: tx = shift[0], LSB first. Shift every div cycles. After bit 7 go to STOP.
  - STOP: tx=1 for div cycles. Then, if FIFO not empty, pop and go to START directly with no idle gap; otherwise go to IDLE.
- Frame length is exactly 10*div cycles. From IDLE, the first start bit appears 1 cycle after the write to an empty FIFO.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Outputs must be glitch-free: tx is driven directly from a flop.

Optional Feature:
- UART_TX_IRQ_EN defined:
  - irq port exists.
  - irq is registered: irq = irq_en & (empty | overflow), updated each clk.
  - CTRL bit0 is R/W.
- UART_TX_IRQ_EN undefined:
  - No irq port and no irq logic.
  - CTRL writes are ignored and reads return 0.

Test Plan:
- Reset, then read STATUS -> rd=0x00000002 one cycle after addr=0x4; tx=1; read DIVISOR -> rd=434.
- DIVISOR=4, write TXDATA=0x55 -> tx pattern over 40 cycles is 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; STATUS busy=1 during the frame, then 0x2.
- DIVISOR=2, write 0x41 and 0x42 back-to-back -> two frames of 20 cycles each with no idle gap; LSB-first bits match.
- DIVISOR=100, write 17 bytes -> 1st pops immediately and 16 fill the FIFO; 18th write sets STATUS=0x0000100D (count 16, full, overflow, busy); STATUS write 0x8 clears overflow.
- DIVISOR=8, assert reset at cycle 30 of a frame -> tx=1 immediately, STATUS=0x2 after release, no residual frame.
- With UART_TX_IRQ_EN: CTRL=1, FIFO empty -> irq=1 one cycle after the write; write 0x10 -> irq=0 the next cycle, irq=1 again once the FIFO drains.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO drained by a serializer onto tx.
// Define UART_TX_IRQ_EN to add the CTRL.irq_en register and the irq output.
module mmio_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_DIV);

  typedef enum logic [1:0] {A_TXDATA, A_STATUS, A_DIVISOR, A_CTRL} reg_e;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [1:0] reg_sel;
  assign reg_sel = addr[3:2];

  logic unused_ok;
  assign unused_ok = ^{addr[31:4], addr[1:0], wd[31:16]};

  // ---------------- TX FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          full, empty, push_req, push, pop;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push_req = we && (reg_sel == A_TXDATA);
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wd[7:0];
  end

  // ---------------- control registers ----------------
  logic        ovf;
  logic [15:0] div_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf     <= 1'b0;
      div_reg <= DIV_RST;
    end else begin
      if (push_req && !push)                        ovf <= 1'b1;
      else if (we && reg_sel == A_STATUS && wd[3])  ovf <= 1'b0;
      if (we && reg_sel == A_DIVISOR) div_reg <= wd[15:0];
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (we && reg_sel == A_CTRL) irq_en <= wd[0];
      irq <= irq_en & (empty | ovf);
    end
  end
`endif

  // ---------------- serializer ----------------
  state_e      state, state_d;
  logic [15:0] bit_cnt, bit_cnt_d, div_lat, div_lat_d, div_eff;
  logic [7:0]  shift, shift_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic        bit_end, tx_d;

  assign bit_end = (bit_cnt == 16'd0);
  assign div_eff = (div_reg == 16'd0) ? 16'd1 : div_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      div_lat <= 16'd1;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      div_lat <= div_lat_d;
      shift   <= shift_d;
      bit_idx <= bit_idx_d;
      tx      <= tx_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (!empty) state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && bit_idx == 3'd7) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = empty ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // Each bit loads div-1 and counts down to 0, giving exactly div cycles per bit.
  always_comb begin
    pop       = 1'b0;
    shift_d   = shift;
    bit_idx_d = bit_idx;
    div_lat_d = div_lat;
    bit_cnt_d = bit_end ? div_lat - 16'd1 : bit_cnt - 16'd1;
    case (state)
      S_IDLE: begin
        bit_cnt_d = bit_cnt;
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem[rptr];
          div_lat_d = div_eff;
          bit_cnt_d = div_eff - 16'd1;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (bit_end && !empty) begin
          pop       = 1'b1;
          shift_d   = mem[rptr];
          div_lat_d = div_eff;
          bit_cnt_d = div_eff - 16'd1;
          bit_idx_d = 3'd0;
        end
      end
      default: ;
    endcase
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------- read port ----------------
  logic [31:0] rd_d;

  always_comb begin
    rd_d = '0;
    case (reg_sel)
      A_STATUS: begin
        rd_d[0]      = full;
        rd_d[1]      = empty;
        rd_d[2]      = (state != S_IDLE);
        rd_d[3]      = ovf;
        rd_d[8 +: CW] = count;
      end
      A_DIVISOR: rd_d[15:0] = div_reg;
      A_CTRL: begin
`ifdef UART_TX_IRQ_EN
        rd_d[0] = irq_en;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd <= '0;
    else       rd <= rd_d;
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: byte-queue/frame-timeline model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_mmio_uart_tx;
  localparam int DEPTH = 16;

  logic        clk = 1'b0, reset = 1'b1, we = 1'b0;
  logic [31:0] addr = '0, wd = '0, rd;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif
  int n_cmp = 0, n_bad = 0;

  mmio_uart_tx #(.CLK_DIV(434), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wd(wd), .rd(rd), .tx(tx)
`ifdef UART_TX_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: byte queue + current frame timeline ----------------
  logic [7:0]  mq[$];
  logic        m_ovf = 1'b0, m_active = 1'b0, m_irq_en = 1'b0, m_irq = 1'b0, m_tx = 1'b1;
  logic [15:0] m_div = 16'd434;
  logic [7:0]  m_byte = '0;
  logic [31:0] m_rd = '0, m_st;
  int          m_fdiv = 1;
  longint      m_edge = 0, m_t0 = 0;

  function automatic logic [31:0] m_status();
    return {19'd0, 5'(mq.size()), 4'd0, m_ovf, m_active, mq.size() == 0, mq.size() == DEPTH};
  endfunction

  // Frame bit k: start(0), data LSB first, stop(1).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_active = 0; m_div = 16'd434; m_irq_en = 0; m_irq = 0; m_rd = 0; m_tx = 1;
    end else begin
      m_st = m_status();
      case (addr[3:2])
        2'd1:    m_rd = m_st;
        2'd2:    m_rd = {16'd0, m_div};
`ifdef UART_TX_IRQ_EN
        2'd3:    m_rd = {31'd0, m_irq_en};
`endif
        default: m_rd = 32'd0;
      endcase
      m_irq = m_irq_en & ((mq.size() == 0) | m_ovf);
      m_edge++;
      if (!m_active || (m_edge - m_t0) == longint'(10 * m_fdiv)) begin
        m_active = 0;
        if (mq.size() > 0) begin
          m_byte = mq.pop_front();
          m_active = 1;
          m_t0 = m_edge;
          m_fdiv = (m_div == 0) ? 1 : int'(m_div);
        end
      end
      if (we) begin
        case (addr[3:2])
          2'd0: if (mq.size() < DEPTH) mq.push_back(wd[7:0]); else m_ovf = 1;
          2'd1: if (wd[3]) m_ovf = 0;
          2'd2: m_div = wd[15:0];
`ifdef UART_TX_IRQ_EN
          2'd3: m_irq_en = wd[0];
`endif
          default: ;
        endcase
      end
      m_tx = m_active ? frame_bit(m_byte, int'((m_edge - m_t0) / m_fdiv)) : 1'b1;
    end
  end

  initial forever begin
    @(posedge clk); #2;
    check("tx", {31'd0, tx}, {31'd0, m_tx});
    check("rd", rd, m_rd);
`ifdef UART_TX_IRQ_EN
    check("irq", {31'd0, irq}, {31'd0, m_irq});
`endif
  end

  // ---------------- directed stimulus (tasks start and end on a negedge) ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rdreg(input logic [31:0] a, output logic [31:0] d);
    we = 1'b0; addr = a;
    @(negedge clk);
    d = rd;
  endtask

  logic [31:0] r;
  logic [9:0]  f55 = 10'b10_1010_1010;  // bit k = frame bit k
  logic [9:0]  f41 = 10'b10_1000_0010;
  logic [9:0]  f42 = 10'b10_1000_0100;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state
    check("tx_after_reset", {31'd0, tx}, 32'd1);
    rdreg(32'h4, r);  check("status_reset", r, 32'h0000_0002);
    rdreg(32'h8, r);  check("divisor_reset", r, 32'd434);
    rdreg(32'hC, r);  check("ctrl_reset", r, 32'd0);
    rdreg(32'h0, r);  check("txdata_reads0", r, 32'd0);

    // 0x55 at div 4, mid-bit samples, busy seen via STATUS
    wr(32'h8, 32'd4);
    wr(32'h0, 32'h55);
    addr = 32'h4;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("tx_55_bit", {31'd0, tx}, {31'd0, f55[k]});
      check("busy_55", {31'd0, rd[2]}, 32'd1);
      repeat (4) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    rdreg(32'h4, r);  check("status_after_55", r, 32'h0000_0002);

    // back-to-back 0x41, 0x42 at div 2, no idle gap
    wr(32'h8, 32'd2);
    wr(32'h0, 32'h41);
    wr(32'h0, 32'h42);
    for (int j = 0; j < 20; j++) begin
      if (j < 10) check("tx_41_bit", {31'd0, tx}, {31'd0, f41[j]});
      else        check("tx_42_bit", {31'd0, tx}, {31'd0, f42[j-10]});
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);

    // divisor width and the zero divisor
    wr(32'h8, 32'h0001_0005);
    rdreg(32'h8, r);  check("divisor_16bit", r, 32'd5);
    wr(32'h8, 32'd0);
    rdreg(32'h8, r);  check("divisor_zero_rd", r, 32'd0);
    wr(32'h0, 32'hA5);
    @(negedge clk);   check("div0_start", {31'd0, tx}, 32'd0);
    @(negedge clk);   check("div0_bit0", {31'd0, tx}, 32'd1);
    repeat (12) @(negedge clk);

    // divisor changed mid-frame applies to the next frame (model-checked)
    wr(32'h8, 32'd3);
    wr(32'h0, 32'h3C);
    wr(32'h0, 32'hC3);
    repeat (5) @(negedge clk);
    wr(32'h8, 32'd5);
    repeat (90) @(negedge clk);

    // fill, overflow, sticky clear
    wr(32'h8, 32'd100);
    for (int i = 0; i < 17; i++) wr(32'h0, 32'h30 + i);
    rdreg(32'h4, r);  check("status_full", r, 32'h0000_1005);
    wr(32'h0, 32'hEE);
    rdreg(32'h4, r);  check("status_overflow", r, 32'h0000_100D);
    wr(32'h4, 32'h7);
    rdreg(32'h4, r);  check("ovf_not_cleared", r, 32'h0000_100D);
    wr(32'h4, 32'h8);
    rdreg(32'h4, r);  check("ovf_cleared", r, 32'h0000_1005);
    // keep writing across the first frame end: push+pop while full is accepted
    for (int i = 0; i < 1000; i++) wr(32'h0, 32'h77);
    repeat (17100) @(negedge clk);
    rdreg(32'h4, r);  check("drained_ovf", r, 32'h0000_000A);
    wr(32'h4, 32'h8);
    rdreg(32'h4, r);  check("drained_clear", r, 32'h0000_0002);

    // reset mid-frame
    wr(32'h8, 32'd8);
    wr(32'h0, 32'h96);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    #1 check("tx_reset_abort", {31'd0, tx}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    rdreg(32'h4, r);  check("status_post_reset", r, 32'h0000_0002);
    rdreg(32'h8, r);  check("divisor_post_reset", r, 32'd434);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i % 25 == 0) check("no_residual_frame", {31'd0, tx}, 32'd1);
    end

`ifdef UART_TX_IRQ_EN
    wr(32'h8, 32'd2);
    wr(32'hC, 32'd1);
    @(negedge clk);   check("irq_set", {31'd0, irq}, 32'd1);
    wr(32'h0, 32'h10);
    @(negedge clk);   check("irq_clr", {31'd0, irq}, 32'd0);
    repeat (25) @(negedge clk);
    check("irq_drained", {31'd0, irq}, 32'd1);
    rdreg(32'hC, r);  check("ctrl_rd", r, 32'd1);
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
